// File: rtl/prog_loader_if.sv
// prog_loader_if: word-stream handshake carrying the boot image into the loader.
//   in_valid  source has a word on in_data
//   in_data   9-bit stream word (headers, instructions, data bytes in [7:0])
//   in_ready  loader accepts a word this cycle; a transfer is in_valid && in_ready
// Modports: master = stream source, slave = loader.
interface prog_loader_if;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time program/data loader and run supervisor for the 9-bit core.
// Consumes a stream: IM header N, N instruction words, DM header M, M data bytes; writes
// them into the core's instruction/data memories, pulses start for one cycle, then waits
// for done.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_if (slave)     valid/ready word stream
//   rearm             returns DONE/ERR to the IM header state
//   im_we/addr/wdata  instruction memory write port (registered, one cycle per word)
//   dm_we/addr/wdata  data memory write port (registered, one cycle per byte)
//   start, done       core launch pulse / completion flag
//   busy, finished, err  status decode of the loader state
//   cycle_count       run length of the core in cycles
// Optional feature: define LOADER_CYCLE_COUNT_EN to build the 16-bit saturating run counter;
// otherwise cycle_count is tied to zero.
module prog_loader #(
  parameter int unsigned IM_SIZE = 256,
  parameter int unsigned DM_SIZE = 64
) (
  input  logic               clk,
  input  logic               reset,
  prog_loader_if.slave       in_if,
  input  logic               rearm,
  output logic               im_we,
  output logic [9:0]         im_addr,
  output logic [8:0]         im_wdata,
  output logic               dm_we,
  output logic [7:0]         dm_addr,
  output logic [7:0]         dm_wdata,
  output logic               start,
  input  logic               done,
  output logic               busy,
  output logic               finished,
  output logic               err,
  output logic [15:0]        cycle_count
);

  typedef enum logic [2:0] {
    StImHdr, StImLoad, StDmHdr, StDmLoad, StLaunch, StRun, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;    // next write address within the current section
  logic [9:0]  len_q, len_d;    // word count of the current section
  logic        im_we_q, im_we_d;
  logic [9:0]  im_addr_q, im_addr_d;
  logic [8:0]  im_wdata_q, im_wdata_d;
  logic        dm_we_q, dm_we_d;
  logic [7:0]  dm_addr_q, dm_addr_d;
  logic [7:0]  dm_wdata_q, dm_wdata_d;
  logic        start_q, start_d;
  logic        ready;
  logic        xfer;

  // Status decodes are forced to their reset values while reset is high.
  assign ready = ~reset & ((state_q == StImHdr) | (state_q == StImLoad) |
                           (state_q == StDmHdr) | (state_q == StDmLoad));
  assign in_if.in_ready = ready;
  assign xfer = in_if.in_valid & ready;

  assign busy     = reset | ~((state_q == StDone) | (state_q == StErr));
  assign finished = ~reset & (state_q == StDone);
  assign err      = ~reset & (state_q == StErr);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    unique case (state_q)
      StImHdr: begin
        if (xfer) begin
          idx_d = '0;
          len_d = {1'b0, in_if.in_data};
          // Counts are validated here so addresses can never wrap during the load.
          if (32'(in_if.in_data) > IM_SIZE)  state_d = StErr;
          else if (in_if.in_data == 9'd0)    state_d = StDmHdr;
          else                               state_d = StImLoad;
        end
      end
      StImLoad: begin
        if (xfer) begin
          im_we_d    = 1'b1;
          im_addr_d  = idx_q;
          im_wdata_d = in_if.in_data;
          idx_d      = idx_q + 10'd1;
          if (idx_q + 10'd1 == len_q) state_d = StDmHdr;
        end
      end
      StDmHdr: begin
        if (xfer) begin
          idx_d = '0;
          len_d = {1'b0, in_if.in_data};
          if (32'(in_if.in_data) > DM_SIZE)  state_d = StErr;
          else if (in_if.in_data == 9'd0)    state_d = StLaunch;
          else                               state_d = StDmLoad;
        end
      end
      StDmLoad: begin
        if (xfer) begin
          dm_we_d    = 1'b1;
          dm_addr_d  = idx_q[7:0];
          dm_wdata_d = in_if.in_data[7:0];
          idx_d      = idx_q + 10'd1;
          // The final byte's write lands in the LAUNCH cycle, ahead of the core's first fetch.
          if (idx_q + 10'd1 == len_q) state_d = StLaunch;
        end
      end
      StLaunch: state_d = StRun;      // done seen here is deliberately ignored
      StRun:    if (done) state_d = StDone;
      StDone:   if (rearm) state_d = StImHdr;
      StErr:    if (rearm) state_d = StImHdr;
      default:  state_d = StImHdr;
    endcase
    start_d = (state_d == StLaunch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StImHdr;
      idx_q      <= '0;
      len_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      start_q    <= start_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign start    = start_q;

`ifdef LOADER_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Cleared as LAUNCH is entered, counts every RUN cycle (including the one that sees done),
  // saturates, and holds its value through DONE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StLaunch)                          cnt_d = '0;
    else if ((state_q == StRun) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: builds boot streams, records every memory write and
// start pulse, and compares them with the write list and timing implied by the stream.
module tb_prog_loader;
  localparam int unsigned IM_SIZE = 256;
  localparam int unsigned DM_SIZE = 64;

  logic        clk = 1'b0;
  logic        reset, rearm, done;
  logic        im_we, dm_we, start, busy, finished, err;
  logic [9:0]  im_addr;
  logic [8:0]  im_wdata;
  logic [7:0]  dm_addr, dm_wdata;
  logic [15:0] cycle_count;

  prog_loader_if bus ();

  prog_loader #(.IM_SIZE(IM_SIZE), .DM_SIZE(DM_SIZE)) dut (
    .clk(clk), .reset(reset), .in_if(bus), .rearm(rearm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .start(start), .done(done), .busy(busy), .finished(finished), .err(err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write/start monitor, sampled mid-cycle.
  logic [63:0] im_got[$];
  logic [63:0] dm_got[$];
  int          start_got[$];
  always @(negedge clk) begin
    if (im_we === 1'b1) im_got.push_back({32'(cyc), 13'd0, im_addr, im_wdata});
    if (dm_we === 1'b1) dm_got.push_back({32'(cyc), 16'd0, dm_addr, dm_wdata});
    if (start === 1'b1) start_got.push_back(cyc);
  end

  logic [8:0] stream_q[$];
  int         xfer_q[$];

  function automatic logic [63:0] exp_cnt(input int d);
`ifdef LOADER_CYCLE_COUNT_EN
    return 64'(d);
`else
    return 64'(d - d);
`endif
  endfunction

  task automatic clear_mon();
    im_got.delete();
    dm_got.delete();
    start_got.delete();
  endtask

  task automatic build_stream(input int n, input int m);
    stream_q.delete();
    stream_q.push_back(9'(n));
    for (int i = 0; i < n; i++) stream_q.push_back(9'($urandom));
    stream_q.push_back(9'(m));
    for (int j = 0; j < m; j++) stream_q.push_back(9'($urandom));
  endtask

  // gap: 0 continuous, 1 one idle cycle between words, 2 random idles. Returns at the
  // negedge of the cycle after the last transfer.
  task automatic send_stream(input int gap);
    logic accepted;
    int   idle;
    xfer_q.delete();
    foreach (stream_q[i]) begin
      idle = (gap == 0) ? 0 : (gap == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 3));
      repeat (idle) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 9'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stream_q[i];
      accepted = 1'b0;
      for (int k = 0; k < 100 && !accepted; k++) begin
        accepted = bus.in_ready;
        if (accepted) xfer_q.push_back(cyc);
        @(negedge clk);
      end
      if (!accepted) begin
        check("xfer_timeout", 64'(accepted), 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Loads stream_q, then raises done d cycles after the start cycle (and also during the
  // start cycle when early is set); checks writes, start timing, DONE and the run count.
  task automatic run_prog(input int gap, input int d, input bit early);
    int n, m, l;
    logic [63:0] exp_im[$];
    logic [63:0] exp_dm[$];
    clear_mon();
    n = int'(stream_q[0]);
    m = int'(stream_q[n + 1]);
    send_stream(gap);
    if (xfer_q.size() != stream_q.size()) return;
    for (int i = 0; i < n; i++)
      exp_im.push_back({32'(xfer_q[1 + i] + 1), 13'd0, 10'(i), stream_q[1 + i]});
    for (int j = 0; j < m; j++)
      exp_dm.push_back({32'(xfer_q[n + 2 + j] + 1), 16'd0, 8'(j), stream_q[n + 2 + j][7:0]});
    for (int k = 0; k < 20 && start !== 1'b1; k++) @(negedge clk);
    check("start_seen", 64'(start), 64'd1);
    if (start !== 1'b1) return;
    l = cyc;
    check("start_cycle", 64'(l), 64'(xfer_q[xfer_q.size() - 1] + 1));
    done = early;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("run_start_low", 64'(start), 64'd0);
        check("run_not_fin", 64'(finished), 64'd0);
        check("run_busy", 64'(busy), 64'd1);
      end
      done = (k == d);
    end
    @(negedge clk);
    done = 1'b0;
    check("finished", 64'(finished), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("cycle_count", 64'(cycle_count), exp_cnt(d));
    check("im_wr_count", 64'(im_got.size()), 64'(exp_im.size()));
    for (int i = 0; i < exp_im.size() && i < im_got.size(); i++) check("im_wr", im_got[i], exp_im[i]);
    check("dm_wr_count", 64'(dm_got.size()), 64'(exp_dm.size()));
    for (int j = 0; j < exp_dm.size() && j < dm_got.size(); j++) check("dm_wr", dm_got[j], exp_dm[j]);
    check("start_pulses", 64'(start_got.size()), 64'd1);
    // rearm returns to the IM header state
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_ready", 64'(bus.in_ready), 64'd1);
    check("rearm_fin", 64'(finished), 64'd0);
  endtask

  // Stream whose IM or DM header exceeds the memory depth.
  task automatic run_err(input bit dm_side, input logic [8:0] hdr);
    clear_mon();
    stream_q.delete();
    if (dm_side) stream_q.push_back(9'd0);
    stream_q.push_back(hdr);
    send_stream(0);
    check("err_flag", 64'(err), 64'd1);
    check("err_ready", 64'(bus.in_ready), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("err_hold", 64'(err), 64'd1);
    check("err_no_writes", 64'(im_got.size() + dm_got.size() + start_got.size()), 64'd0);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("err_rearm_ready", 64'(bus.in_ready), 64'd1);
    check("err_rearm_clr", 64'(err), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_im"}, {45'd0, im_we, im_addr, im_wdata}, 64'd0);
    check({tag, "_dm"}, {47'd0, dm_we, dm_addr, dm_wdata}, 64'd0);
    check({tag, "_flags"}, {60'd0, start, busy, finished, err}, 64'b0100);
    check({tag, "_count"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    rearm = 1'b0;
    done  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(bus.in_ready), 64'd1);

    // Directed load, continuous then toggling valid.
    for (int g = 0; g < 2; g++) begin
      stream_q = '{9'd3, 9'h1A0, 9'h0F3, 9'h155, 9'd2, 9'h05A, 9'h0C3};
      run_prog(g, 7, 1'b0);
    end
    // Empty program; done 10 cycles after start.
    build_stream(0, 0);
    run_prog(0, 10, 1'b0);
    // done during LAUNCH ignored, second assertion 5 cycles later counts.
    build_stream(2, 1);
    run_prog(0, 5, 1'b1);
    // Oversized headers.
    run_err(1'b0, 9'd257);
    run_err(1'b1, 9'd65);
    // Full-depth boundary.
    build_stream(IM_SIZE, DM_SIZE);
    run_prog(0, 3, 1'b0);

    // Reset after 2 of 4 IM words, then a fresh load from address 0.
    clear_mon();
    stream_q = '{9'd4, 9'h111, 9'h0AA};
    send_stream(0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    @(negedge clk);
    check("midreset_partial", 64'(im_got.size()), 64'd2);
    build_stream(4, 3);
    run_prog(0, 4, 1'b0);

    // Randomized streams.
    for (int it = 0; it < 10; it++) begin
      build_stream(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      run_prog(int'($urandom_range(0, 2)), int'($urandom_range(1, 25)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program/data loader and run supervisor sitting directly upstream of the 9-bit CPU core. Accepts a word stream over a valid/ready handshake, writes it into instruction memory and data memory, then issues the one-cycle `start` pulse to the core and waits for its `done`. Optionally measures the core's execution time in cycles. The core's instruction/data memories expose their write ports to this block during load; the core is held idle until `start`.

## Interface
Parameters:
- IM_SIZE, 256, instruction memory depth in 9-bit words (max 512)
- DM_SIZE, 64, data memory depth in bytes (max 256)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  stream word valid
- in_data  input  9  stream word
- in_ready  output  1  loader accepts a word this cycle
- rearm  input  1  one-cycle pulse; returns DONE/ERR to IM_HDR
- im_we  output  1  instruction memory write strobe
- im_addr  output  10  instruction memory write address
- im_wdata  output  9  instruction memory write data
- dm_we  output  1  data memory write strobe
- dm_addr  output  8  data memory write address
- dm_wdata  output  8  data memory write data
- start  output  1  core start pulse
- done  input  1  core completion flag
- busy  output  1  high in any state except DONE/ERR
- finished  output  1  high in DONE
- err  output  1  high in ERR
- cycle_count  output  16  core run length in cycles

## Operation
- Stream format: IM header (instruction count N, 0..IM_SIZE), N instruction words, DM header (byte count M, 0..DM_SIZE), M data words (only in_data[7:0] used; bit 8 ignored).
- Transfer occurs on a cycle with in_valid && in_ready.
- States: IM_HDR, IM_LOAD, DM_HDR, DM_LOAD, LAUNCH, RUN, DONE, ERR. Reset -> IM_HDR.
- IM_HDR: on transfer, N>IM_SIZE -> ERR; N==0 -> DM_HDR; else latch N, address 0 -> IM_LOAD.
- IM_LOAD: each transfer writes word at current address, address+1; after Nth word -> DM_HDR.
- DM_HDR: same as IM_HDR with M and DM_SIZE; M==0 -> LAUNCH; else -> DM_LOAD.
- DM_LOAD: each transfer writes byte; after Mth -> LAUNCH.
- LAUNCH: start=1 for exactly this one cycle -> RUN.
- RUN: wait for done==1 -> DONE. done sampled high during LAUNCH is ignored.
- DONE/ERR: hold until rearm (-> IM_HDR) or reset. rearm in any other state ignored.
- in_ready=1 only in IM_HDR, IM_LOAD, DM_HDR, DM_LOAD.
- Addresses never wrap: counts validated against depth at header time.

## Timing
- Reset values: in_ready=0 during reset cycle (1 the cycle after), im_we=0, dm_we=0, im_addr=0, dm_addr=0, im_wdata=0, dm_wdata=0, start=0, busy=1, finished=0, err=0, cycle_count=0.
- Write latency 1: transfer in cycle t -> we/addr/wdata registered, valid in cycle t+1 for one cycle only.
- Back-to-back transfers give back-to-back writes; in_valid low stalls with no write.
- Last DM write (cycle t+1) coincides with LAUNCH; start rises at t+1, after all memory writes issue at or before t+1 (memory commits at the t+1 edge, before core's first fetch at t+2).
- ERR entered the cycle after the offending header transfer; err rises same cycle.
- cycle_count cleared on entry to LAUNCH, increments each RUN cycle, saturates at 0xFFFF; frozen in DONE.
- Reset mid-load: state, addresses, counter cleared next edge; partial memory contents not erased.

## Configuration
- LOADER_CYCLE_COUNT_EN: defined -> 16-bit run counter as above. Undefined -> counter logic removed, cycle_count tied to 0; all other behaviour identical.

## Test plan
- Load N=3 words 0x1A0,0x0F3,0x155, M=2 bytes 0x5A,0xC3 with continuous valid -> im writes addr 0..2 in consecutive cycles, dm writes addr 0..1, start high exactly one cycle right after last dm write.
- Same stream with in_valid toggling every other cycle -> identical writes, no duplicate or missing strobes.
- N=0, M=0 -> no writes; start pulses the cycle after DM header; done asserted 10 cycles after start -> finished=1, cycle_count=10 (with macro), 0 without.
- IM header 257 (IM_SIZE=256) -> err=1, in_ready=0, no writes; rearm -> IM_HDR, in_ready=1.
- done held high during LAUNCH then low, high 5 cycles later -> DONE only on second assertion; cycle_count=5.
- reset asserted after 2 of 4 IM words -> all outputs at reset values next cycle; fresh stream loads from addr 0.
